// File: rtl/fabric_cfg_pkg.sv
// Shared definitions for the fabric configuration loader: FSM states,
// write-target select encodings and stream header field positions.
package fabric_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_ADDR,
        S_DATA,
        S_CHK,
        S_SETTLE,
        S_DONE,
        S_ERR
    } cfg_state_t;

    localparam logic CFG_SEL_LUT = 1'b0;
    localparam logic CFG_SEL_SW  = 1'b1;

    // Header word: record count in the low half-word.
    localparam int HDR_CNT_LSB = 0;
    localparam int HDR_CNT_MSB = 15;
    // Address word: target select in the top bit.
    localparam int HDR_SEL_BIT = 32;

endpackage

// File: rtl/fabric_cfg_checksum.sv
// Running XOR accumulator over the address/data words of one load, with a
// combinational compare against the trailer word. Only instantiated when
// FABRIC_CFG_CHECKSUM_EN is defined.
module fabric_cfg_checksum #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_data,
    input  logic [W-1:0] i_cmp,
    output logic         o_match
);

    logic [W-1:0] r_acc;

    // Accumulate; a new load clears the sum before its first word arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc ^ i_data;
        end
    end

    assign o_match = (r_acc == i_cmp);

endmodule

// File: rtl/fabric_config_loader.sv
// Loads the configurable fabric from a header + address/data record stream
// and holds the fabric in reset until the load completes.
// Optional feature: define FABRIC_CFG_CHECKSUM_EN to require an XOR trailer
// word after the last record.
module fabric_config_loader
    import fabric_cfg_pkg::*;
#(
    parameter int LUT_W  = 33,
    parameter int SW_W   = 16,
    parameter int N_LUT  = 16,
    parameter int N_SW   = 40,
    parameter int ADDR_W = 6,
    parameter int SETTLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LUT_W-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cfg_we,
    output logic              cfg_sel,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [LUT_W-1:0]  cfg_data,
    output logic              fabric_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error
);

    if (SW_W < 1 || SW_W > LUT_W || SETTLE < 1 || SETTLE > 15) begin : g_bad_param
        $error("fabric_config_loader: SW_W must fit in LUT_W and SETTLE must be 1..15");
    end

    localparam logic [3:0]      SETTLE_LD = 4'(SETTLE - 1);
    localparam logic [ADDR_W:0] LUT_LIM   = (ADDR_W + 1)'(N_LUT);
    localparam logic [ADDR_W:0] SW_LIM    = (ADDR_W + 1)'(N_SW);

    cfg_state_t        r_state, w_next;
    logic [15:0]       r_remain;
    logic [3:0]        r_settle;
    logic              r_sel;
    logic [ADDR_W-1:0] r_addr;
    logic              r_cfg_we;
    logic              r_cfg_sel;
    logic [ADDR_W-1:0] r_cfg_addr;
    logic [LUT_W-1:0]  r_cfg_data;

    logic              w_xfer;
    logic              w_start_ok;
    logic [15:0]       w_hdr_cnt;
    logic              w_in_sel;
    logic [ADDR_W-1:0] w_in_addr;
    logic              w_addr_bad;
    logic              w_last;
    logic              w_chk_match;

    assign in_ready     = (r_state == S_HDR) || (r_state == S_ADDR) ||
                          (r_state == S_DATA) || (r_state == S_CHK);
    assign busy         = in_ready || (r_state == S_SETTLE);
    assign done         = (r_state == S_DONE);
    assign error        = (r_state == S_ERR);
    assign fabric_rst_n = (r_state == S_DONE);

    assign w_xfer     = in_valid && in_ready;
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                  (r_state == S_ERR));
    assign w_hdr_cnt  = in_data[HDR_CNT_MSB:HDR_CNT_LSB];
    assign w_in_sel   = in_data[HDR_SEL_BIT];
    assign w_in_addr  = in_data[ADDR_W-1:0];
    assign w_addr_bad = (w_in_sel == CFG_SEL_LUT) ? ({1'b0, w_in_addr} >= LUT_LIM)
                                                  : ({1'b0, w_in_addr} >= SW_LIM);
    // The record being accepted in DATA is the last one when one remains.
    assign w_last     = (r_remain == 16'd1);

`ifdef FABRIC_CFG_CHECKSUM_EN
    fabric_cfg_checksum #(.W(LUT_W)) u_checksum (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_start_ok),
        .i_en    (w_xfer && ((r_state == S_ADDR) || (r_state == S_DATA))),
        .i_data  (in_data),
        .i_cmp   (in_data),
        .o_match (w_chk_match)
    );
`else
    assign w_chk_match = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state decode; stalls (no handshake) hold the current state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: if (start) w_next = S_HDR;
            S_HDR:    if (w_xfer) w_next = (w_hdr_cnt == 16'd0) ? S_ERR : S_ADDR;
            S_ADDR:   if (w_xfer) w_next = w_addr_bad ? S_ERR : S_DATA;
            S_DATA: begin
                if (w_xfer) begin
`ifdef FABRIC_CFG_CHECKSUM_EN
                    w_next = w_last ? S_CHK : S_ADDR;
`else
                    w_next = w_last ? S_SETTLE : S_ADDR;
`endif
                end
            end
            S_CHK:    if (w_xfer) w_next = w_chk_match ? S_SETTLE : S_ERR;
            S_SETTLE: if (r_settle == 4'd0) w_next = S_DONE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Record counter and latched target of the record in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_remain <= '0;
            r_sel    <= CFG_SEL_LUT;
            r_addr   <= '0;
        end else if (w_xfer && (r_state == S_HDR)) begin
            r_remain <= w_hdr_cnt;
        end else if (w_xfer && (r_state == S_ADDR)) begin
            r_sel    <= w_in_sel;
            r_addr   <= w_in_addr;
        end else if (w_xfer && (r_state == S_DATA)) begin
            r_remain <= r_remain - 16'd1;
        end
    end

    // Registered write bus: one strobe in the cycle after each DATA handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cfg_we   <= 1'b0;
            r_cfg_sel  <= CFG_SEL_LUT;
            r_cfg_addr <= '0;
            r_cfg_data <= '0;
        end else begin
            r_cfg_we <= w_xfer && (r_state == S_DATA);
            if (w_xfer && (r_state == S_DATA)) begin
                r_cfg_sel  <= r_sel;
                r_cfg_addr <= r_addr;
                r_cfg_data <= in_data;
            end
        end
    end

    // Settle countdown, loaded on entry so SETTLE cycles are spent there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_settle <= '0;
        end else if ((w_next == S_SETTLE) && (r_state != S_SETTLE)) begin
            r_settle <= SETTLE_LD;
        end else if ((r_state == S_SETTLE) && (r_settle != 4'd0)) begin
            r_settle <= r_settle - 4'd1;
        end
    end

    assign cfg_we   = r_cfg_we;
    assign cfg_sel  = r_cfg_sel;
    assign cfg_addr = r_cfg_addr;
    assign cfg_data = r_cfg_data;

endmodule

// File: tb/tb_fabric_config_loader.sv
// Scoreboard bench for fabric_config_loader: expected writes are queued as
// data words are driven and popped when the write strobe appears.
module tb_fabric_config_loader;

    localparam int LUT_W  = 33;
    localparam int SW_W   = 16;
    localparam int N_LUT  = 16;
    localparam int N_SW   = 40;
    localparam int ADDR_W = 6;
    localparam int SETTLE = 4;

    typedef struct packed {
        logic              sel;
        logic [ADDR_W-1:0] addr;
        logic [LUT_W-1:0]  data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LUT_W-1:0]  in_data;
    logic              in_valid;
    logic              in_ready;
    logic              cfg_we;
    logic              cfg_sel;
    logic [ADDR_W-1:0] cfg_addr;
    logic [LUT_W-1:0]  cfg_data;
    logic              fabric_rst_n;
    logic              busy;
    logic              done;
    logic              error;

    wr_t               exp_q[$];
    logic              ld_sel[$];
    logic [ADDR_W-1:0] ld_addr[$];
    logic [LUT_W-1:0]  ld_data[$];
    int                n_checks = 0;
    int                n_pass   = 0;
    int                wr_count = 0;

    fabric_config_loader #(
        .LUT_W(LUT_W), .SW_W(SW_W), .N_LUT(N_LUT), .N_SW(N_SW),
        .ADDR_W(ADDR_W), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .cfg_we(cfg_we),
        .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .fabric_rst_n(fabric_rst_n), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Write monitor: every strobe must match the oldest outstanding record.
    always @(negedge clk) begin
        if (cfg_we === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                check("spurious_we", 64'd1, 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_sel", 64'(cfg_sel), 64'(e.sel));
                check("wr_addr", 64'(cfg_addr), 64'(e.addr));
                check("wr_data", 64'(cfg_data), 64'(e.data));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_cfg_we"}, 64'(cfg_we), 64'd0);
        check({tag, "_cfg_sel"}, 64'(cfg_sel), 64'd0);
        check({tag, "_cfg_addr"}, 64'(cfg_addr), 64'd0);
        check({tag, "_cfg_data"}, 64'(cfg_data), 64'd0);
        check({tag, "_fab_rst_n"}, 64'(fabric_rst_n), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
    endtask

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic send_word(input logic [LUT_W-1:0] w, input int gap);
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_data  = w;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        check("hs_timeout", 64'd0, 64'd1);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic clear_recs();
        ld_sel.delete();
        ld_addr.delete();
        ld_data.delete();
    endtask

    task automatic add_rec(input logic sel, input logic [ADDR_W-1:0] addr,
                           input logic [LUT_W-1:0] data);
        ld_sel.push_back(sel);
        ld_addr.push_back(addr);
        ld_data.push_back(data);
    endtask

    function automatic logic [LUT_W-1:0] addr_word(input logic sel, input logic [ADDR_W-1:0] a);
        logic [LUT_W-1:0] w;
        w = '0;
        w[32] = sel;
        w[ADDR_W-1:0] = a;
        return w;
    endfunction

    // Streams header, queued records and (with the checksum build) trailer.
    // mid_start >= 0 pulses start while the loader waits for that record's data.
    task automatic send_load(input bit gaps, input bit flip, input int mid_start);
        logic [LUT_W-1:0] w;
        logic [LUT_W-1:0] cs;
        int n;
        n  = ld_sel.size();
        cs = '0;
        w  = '0;
        w[15:0] = 16'(n);
        send_word(w, gaps ? int'($urandom_range(0, 2)) : 0);
        for (int i = 0; i < n; i++) begin
            w  = addr_word(ld_sel[i], ld_addr[i]);
            cs = cs ^ w;
            send_word(w, gaps ? int'($urandom_range(0, 2)) : 0);
            if (i == mid_start) start_pulse();
            exp_q.push_back('{ld_sel[i], ld_addr[i], ld_data[i]});
            cs = cs ^ ld_data[i];
            send_word(ld_data[i], gaps ? int'($urandom_range(0, 2)) : 0);
        end
        cs[0] = cs[0] ^ flip;
`ifdef FABRIC_CFG_CHECKSUM_EN
        send_word(cs, gaps ? int'($urandom_range(0, 2)) : 0);
`endif
    endtask

    // Called just after the last handshake edge.
    task automatic expect_done(input string tag);
        repeat (SETTLE - 1) @(posedge clk);
        @(negedge clk);
        check({tag, "_settle_busy"}, 64'(busy), 64'd1);
        check({tag, "_settle_done"}, 64'(done), 64'd0);
        check({tag, "_settle_fab"}, 64'(fabric_rst_n), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_fab_rst_n"}, 64'(fabric_rst_n), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_wq_empty"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_error(input string tag);
        @(negedge clk);
        check({tag, "_error"}, 64'(error), 64'd1);
        check({tag, "_fab_rst_n"}, 64'(fabric_rst_n), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({tag, "_hold_error"}, 64'(error), 64'd1);
        check({tag, "_wq_empty"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wr_base;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("por");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single LUT record.
        clear_recs();
        add_rec(1'b0, 6'd3, 33'h0_DEADBEEF);
        start_pulse();
        check("hdr_in_ready", 64'(in_ready), 64'd1);
        check("hdr_busy", 64'(busy), 64'd1);
        send_load(1'b0, 1'b0, -1);
        expect_done("single");

        // Full adder image: 8 LUT and 33 switch records with stream gaps.
        clear_recs();
        for (int i = 0; i < 8; i++)
            add_rec(1'b0, 6'(i), {1'($urandom_range(0, 1)), 32'($urandom)});
        for (int i = 0; i < 33; i++)
            add_rec(1'b1, 6'(i), {1'($urandom_range(0, 1)), 32'($urandom)});
        wr_base = wr_count;
        start_pulse();
        send_load(1'b1, 1'b0, -1);
        expect_done("image");
        check("image_wr_count", 64'(wr_count - wr_base), 64'd41);

        // Start from DONE reloads; a start during DATA is ignored.
        start_pulse();
        @(negedge clk);
        check("b2b_done_clr", 64'(done), 64'd0);
        check("b2b_fab_low", 64'(fabric_rst_n), 64'd0);
        check("b2b_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        clear_recs();
        add_rec(1'b0, 6'd15, 33'h1_0000_0001);
        add_rec(1'b1, 6'd39, 33'h0_0000_A5A5);
        wr_base = wr_count;
        send_load(1'b0, 1'b0, 0);
        expect_done("b2b");
        check("b2b_wr_count", 64'(wr_count - wr_base), 64'd2);

        // Bad LUT address.
        clear_recs();
        start_pulse();
        send_word(33'd2, 0);
        send_word(addr_word(1'b0, 6'd16), 0);
        expect_error("bad_lut");

        // Bad switch address, starting from ERR.
        start_pulse();
        @(negedge clk);
        check("err_start_clr", 64'(error), 64'd0);
        @(posedge clk);
        #1;
        send_word(33'd1, 0);
        send_word(addr_word(1'b1, 6'd40), 0);
        expect_error("bad_sw");

        // Zero record count.
        start_pulse();
        send_word(33'd0, 0);
        expect_error("zero_n");

        // Reset during the 4th of 5 records.
        clear_recs();
        for (int i = 0; i < 5; i++) add_rec(1'b0, 6'(i + 2), 33'(i * 7 + 1));
        wr_base = wr_count;
        start_pulse();
        send_word(33'd5, 0);
        for (int i = 0; i < 3; i++) begin
            send_word(addr_word(ld_sel[i], ld_addr[i]), 0);
            exp_q.push_back('{ld_sel[i], ld_addr[i], ld_data[i]});
            send_word(ld_data[i], 0);
        end
        send_word(addr_word(ld_sel[3], ld_addr[3]), 0);
        in_data  = ld_data[3];
        in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_vals("midrst");
        check("midrst_wr_count", 64'(wr_count - wr_base), 64'd3);
        check("midrst_wq_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("midrst_hold_we", 64'(cfg_we), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        clear_recs();
        add_rec(1'b1, 6'd7, 33'h1_2345_6789);
        start_pulse();
        send_load(1'b0, 1'b0, -1);
        expect_done("reload");

`ifdef FABRIC_CFG_CHECKSUM_EN
        // Corrupted trailer: writes land but the load fails.
        clear_recs();
        add_rec(1'b0, 6'd1, 33'h0_CAFE_F00D);
        add_rec(1'b1, 6'd2, 33'h1_0000_BEEF);
        start_pulse();
        send_load(1'b0, 1'b1, -1);
        expect_error("bad_csum");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
